fetch_unit: RTL

Front-end fetch stage of the RV64I+Zba 5-stage pipeline. It is the producer of the IF/ID interface that feeds the decode stage.
- Holds the PC and issues in-order requests to the instruction memory.
- Buffers returned instruction words in a small queue.
- Drives the IF/ID register (Instr_D, PC_D, valid_D).
- Handles decode stalls, and execute-stage redirects for taken branch, JAL and JALR.

---
 rtl/fetch_unit.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Fetch stage: PC, in-order imem requests, instruction queue, IF/ID register. FETCH_PERF_EN adds perf counters.
// Latency: request -> response -> queue -> IF/ID; no bypass of an empty queue into IF/ID.
// Backpressure: requests credit-limited to QUEUE_DEPTH (in flight + queued); stall_D holds IF/ID.

module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_vld,
    input  logic                   push_vld,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop_vld,
    output logic [WIDTH-1:0]       head_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    // Caller never pushes when full nor pops when empty; flush discards everything.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_vld) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_vld) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_vld) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(push_vld) - (AW+1)'(pop_vld);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;
endmodule

module fetch_unit #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        stall_D,
    output logic [31:0] Instr_D,
    output logic [63:0] PC_D,
    output logic        valid_D
`ifdef FETCH_PERF_EN
    ,
    output logic [63:0] perf_fetched,
    output logic [63:0] perf_killed
`endif
);
    localparam int          CW      = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(QUEUE_DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } fetch_entry_t;

    logic [63:0]   pc_q, pc_d;
    logic [63:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] kill_q, kill_d;
    logic [31:0]   ifid_instr_q, ifid_instr_d;
    logic [63:0]   ifid_pc_q, ifid_pc_d;
    logic          ifid_vld_q, ifid_vld_d;

    logic          req_vld, req_fire, rsp_fire, rsp_drop, push_vld, pop_vld;
    logic [CW:0]   credit_sum;
    logic [63:0]   redirect_aligned;
    fetch_entry_t  push_dat, head_dat;
    logic [CW-1:0] q_count;

    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush_vld (redirect_valid),
        .push_vld  (push_vld),
        .push_dat  (push_dat),
        .pop_vld   (pop_vld),
        .head_dat  (head_dat),
        .count     (q_count)
    );

    always_comb begin
        redirect_aligned = {redirect_pc[63:2], 2'b00};
        credit_sum       = {1'b0, outstanding_q} + {1'b0, q_count};
        req_vld          = !rst && !redirect_valid && (credit_sum < DEPTH_W);
        req_fire         = req_vld && imem_req_ready;
        // A response with nothing outstanding is stale (e.g. from before reset) and ignored.
        rsp_fire         = imem_rsp_valid && (outstanding_q != '0);
        rsp_drop         = rsp_fire && ((kill_q != '0) || redirect_valid);
        push_vld         = rsp_fire && !rsp_drop;
        push_dat         = {imem_rsp_data, rsp_pc_q};
        pop_vld          = !redirect_valid && !stall_D && (q_count != '0);
    end

    always_comb begin
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
        kill_d        = kill_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_vld_d    = ifid_vld_q;

        if (redirect_valid) begin
            pc_d         = redirect_aligned;
            rsp_pc_d     = redirect_aligned;
            // Everything still in flight belongs to the old path.
            kill_d       = outstanding_d;
            ifid_vld_d   = 1'b0;
            ifid_instr_d = NOP;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + 64'd4;
            end
            if (push_vld) begin
                rsp_pc_d = rsp_pc_q + 64'd4;
            end
            if (rsp_fire && (kill_q != '0)) begin
                kill_d = kill_q - CW'(1);
            end
            if (!stall_D) begin
                if (q_count != '0) begin
                    ifid_instr_d = head_dat.instr;
                    ifid_pc_d    = head_dat.pc;
                    ifid_vld_d   = 1'b1;
                end else begin
                    ifid_instr_d = NOP;
                    ifid_vld_d   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            kill_q        <= '0;
            ifid_instr_q  <= NOP;
            ifid_pc_q     <= RESET_PC;
            ifid_vld_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_vld_q    <= ifid_vld_d;
        end
    end

    assign imem_req_valid = req_vld;
    assign imem_req_addr  = pc_q;
    assign Instr_D        = ifid_instr_q;
    assign PC_D           = ifid_pc_q;
    assign valid_D        = ifid_vld_q;

`ifdef FETCH_PERF_EN
    logic [63:0] perf_fetched_q, perf_fetched_d;
    logic [63:0] perf_killed_q, perf_killed_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + 64'(pop_vld);
        perf_killed_d  = perf_killed_q + 64'(rsp_drop);
        if (redirect_valid) begin
            perf_killed_d = perf_killed_d + 64'(q_count);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_killed_q  <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_killed_q  <= perf_killed_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_killed  = perf_killed_q;
`endif
endmodule
